// File: rtl/rvm_ctrl_fsm.sv
// rvm core multi-cycle control sequencer: fetch/decode/exec/mem/wb over one
// shared memory port, with bus timeout, variable-latency execute, traps and halt.
module rvm_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 15,
    parameter int MDU_CYCLES  = 4,
    parameter int SW          = 4
) (
    input  logic          clk,
    input  logic          reset,
    output logic          mem_req,
    output logic          mem_wen,
    output logic          mem_sel_data,
    input  logic          mem_ack,
    input  logic          mem_err,
    input  logic          dec_load,
    input  logic          dec_store,
    input  logic          dec_multi,
    input  logic          dec_illegal,
    input  logic          dec_misalign,
    input  logic          dec_rd_wen,
    input  logic          irq_pending,
    input  logic          halt_req,
    output logic          ir_wen,
    output logic          pc_wen,
    output logic          rd_wen,
    output logic          trap,
    output logic [3:0]    trap_cause,
    output logic          halted,
    output logic [SW-1:0] dbg_state
);

    localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_MEM    = 3'd3,
        S_EXEC   = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    state_t        state, state_n;
    logic [WW-1:0] wait_cnt;
    logic [7:0]    exec_cnt;
    logic [3:0]    cause_n;
    logic          in_bus, tmo, done, fault;

    assign in_bus = (state == S_FETCH) || (state == S_MEM);
    assign done   = mem_ack & ~mem_err;

    // A stall that would bring wait_cnt up to MEM_TIMEOUT counts as a bus error
    generate
        if (MEM_TIMEOUT == 0) begin : g_no_tmo
            assign tmo = 1'b0;
        end else begin : g_tmo
            assign tmo = (wait_cnt == WW'(MEM_TIMEOUT - 1));
        end
    endgenerate

    assign fault = mem_err | (~mem_ack & tmo);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_RST;
            wait_cnt   <= '0;
            exec_cnt   <= '0;
            trap_cause <= '0;
        end else begin
            state <= state_n;
            if (in_bus && !mem_ack && !fault)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
            if (state_n == S_EXEC && state != S_EXEC)
                exec_cnt <= 8'(MDU_CYCLES - 1);
            else if (state == S_EXEC)
                exec_cnt <= exec_cnt - 8'd1;
            if (state_n == S_TRAP)
                trap_cause <= cause_n;
        end
    end

    always_comb begin
        state_n = state;
        cause_n = trap_cause;
        unique case (state)
            S_RST: state_n = S_FETCH;
            S_FETCH: begin
                if (fault) begin
                    state_n = S_TRAP;
                    cause_n = 4'd1;
                end else if (mem_ack) begin
                    state_n = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec_illegal) begin
                    state_n = S_TRAP;
                    cause_n = 4'd2;
                end else if (dec_load && dec_misalign) begin
                    state_n = S_TRAP;
                    cause_n = 4'd4;
                end else if (dec_store && dec_misalign) begin
                    state_n = S_TRAP;
                    cause_n = 4'd6;
                end else if (dec_load || dec_store) begin
                    state_n = S_MEM;
                end else if (dec_multi) begin
                    state_n = S_EXEC;
                end else begin
                    state_n = S_WB;
                end
            end
            S_MEM: begin
                if (fault) begin
                    state_n = S_TRAP;
                    cause_n = dec_store ? 4'd7 : 4'd5;
                end else if (mem_ack) begin
                    state_n = S_WB;
                end
            end
            S_EXEC: if (exec_cnt == 8'd0) state_n = S_WB;
            S_WB: begin
                if (halt_req) begin
                    state_n = S_HALT;
                end else if (irq_pending) begin
                    state_n = S_TRAP;
                    cause_n = 4'd11;
                end else begin
                    state_n = S_FETCH;
                end
            end
            S_TRAP: state_n = halt_req ? S_HALT : S_FETCH;
            S_HALT: if (!halt_req) state_n = S_FETCH;
            default: state_n = S_RST;
        endcase
    end

    assign mem_req      = in_bus;
    assign mem_wen      = (state == S_MEM) & dec_store;
    assign mem_sel_data = (state == S_MEM);
    assign ir_wen       = (state == S_FETCH) & done;
    assign pc_wen       = (state == S_WB) | (state == S_TRAP);
    assign rd_wen       = (state == S_WB) & dec_rd_wen & ~dec_store;
    assign trap         = (state == S_TRAP);
    assign halted       = (state == S_HALT);
    assign dbg_state    = SW'(state);

endmodule
